pooled_window_reader: RTL and testbench

- Sink for the pooled/ReLU stream produced after conv layer 1: accepts 3 channels of pooled values in raster order, buffers one full IN_HEIGHT x IN_WIDTH frame per channel, then reads it back as KERNEL x KERNEL sliding windows for the conv layer 2 MAC.
- Window traversal: row-major over output positions; taps row-major within each window.
- Output side is a valid/ready stream with window and frame markers.
- Input side has no backpressure from upstream; in_ready is advisory, and drops are flagged.

---
 rtl/pooled_window_reader_pkg.sv | 25 ++
 rtl/pooled_frame_ram.sv | 24 ++
 rtl/pooled_window_reader.sv | 193 +++++++++++++++++++
 tb/tb_pooled_window_reader.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/pooled_window_reader_pkg.sv
// Shared constants, state encoding and pixel payload for the pooled window reader.
package pooled_window_reader_pkg;

  localparam int unsigned CONV_BIT   = 15;
  localparam int unsigned IN_WIDTH   = 12;
  localparam int unsigned IN_HEIGHT  = 12;
  localparam int unsigned KERNEL     = 5;
  localparam int unsigned ADDR_BIT   = 8;
  localparam int unsigned CNT_BIT    = 4;

  localparam int unsigned OUT_DIM    = IN_WIDTH - KERNEL + 1;
  localparam int unsigned OUT_ROWS   = IN_HEIGHT - KERNEL + 1;
  localparam int unsigned FRAME_SIZE = IN_WIDTH * IN_HEIGHT;

  localparam logic [0:0] ST_FILL = 1'b0;
  localparam logic [0:0] ST_READ = 1'b1;

  // One pooled sample across all three channels.
  typedef struct packed {
    logic signed [CONV_BIT-1:0] ch3;
    logic signed [CONV_BIT-1:0] ch2;
    logic signed [CONV_BIT-1:0] ch1;
  } pix_t;

endpackage

// File: rtl/pooled_frame_ram.sv
// Single-channel frame buffer: synchronous write, combinational read.
module pooled_frame_ram
  import pooled_window_reader_pkg::*;
(
  input  logic                       clk,
  input  logic                       we,
  input  logic [ADDR_BIT-1:0]        waddr,
  input  logic signed [CONV_BIT-1:0] wdata,
  input  logic [ADDR_BIT-1:0]        raddr,
  output logic signed [CONV_BIT-1:0] rdata_c
);

  logic signed [CONV_BIT-1:0] mem [FRAME_SIZE];

  // Contents are intentionally not reset; a frame is always fully rewritten before reading.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata_c = mem[raddr];

endmodule

// File: rtl/pooled_window_reader.sv
// Buffers one pooled 3-channel frame, then replays it as KERNELxKERNEL sliding windows.
module pooled_window_reader
  import pooled_window_reader_pkg::*;
(
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       valid_in,
  input  logic signed [CONV_BIT-1:0] data_in_1,
  input  logic signed [CONV_BIT-1:0] data_in_2,
  input  logic signed [CONV_BIT-1:0] data_in_3,
  output logic                       in_ready,
  output logic signed [CONV_BIT-1:0] data_out_1,
  output logic signed [CONV_BIT-1:0] data_out_2,
  output logic signed [CONV_BIT-1:0] data_out_3,
  output logic                       valid_out,
  input  logic                       out_ready,
  output logic                       tap_last,
  output logic                       frame_last,
  output logic                       overflow
);

  localparam logic [CNT_BIT-1:0]  K_MAX    = CNT_BIT'(KERNEL - 1);
  localparam logic [CNT_BIT-1:0]  COL_MAX  = CNT_BIT'(OUT_DIM - 1);
  localparam logic [CNT_BIT-1:0]  ROW_MAX  = CNT_BIT'(OUT_ROWS - 1);
  localparam logic [ADDR_BIT-1:0] LAST_WA  = ADDR_BIT'(FRAME_SIZE - 1);
  localparam logic [ADDR_BIT-1:0] WIDTH_A  = ADDR_BIT'(IN_WIDTH);

  logic [0:0]          state_q, state_d;
  logic [ADDR_BIT-1:0] waddr_q, waddr_d;
  logic [CNT_BIT-1:0]  orow_q, orow_d, ocol_q, ocol_d;
  logic [CNT_BIT-1:0]  ky_q, ky_d, kx_q, kx_d;
  logic                issued_q, issued_d;
  logic                valid_q, valid_d;
  logic                tap_last_q, tap_last_d;
  logic                frame_last_q, frame_last_d;
  logic                overflow_q, overflow_d;
  logic                in_ready_q, in_ready_d;
  pix_t                data_q, data_d;

  logic                we_c;
  logic                advance_c;
  logic                last_tap_c;
  logic                last_win_c;
  logic [ADDR_BIT-1:0] raddr_c;
  pix_t                rd_c;

  // Write strobe, window address and issue qualifiers.
  assign we_c       = (state_q == ST_FILL) && valid_in;
  assign advance_c  = (state_q == ST_READ) && (!valid_q || out_ready) && !issued_q;
  assign last_tap_c = (kx_q == K_MAX) && (ky_q == K_MAX);
  assign last_win_c = (ocol_q == COL_MAX) && (orow_q == ROW_MAX);
  assign raddr_c    = (ADDR_BIT'(orow_q) + ADDR_BIT'(ky_q)) * WIDTH_A
                    + ADDR_BIT'(ocol_q) + ADDR_BIT'(kx_q);

  pooled_frame_ram u_ram_1 (
    .clk     (clk),
    .we      (we_c),
    .waddr   (waddr_q),
    .wdata   (data_in_1),
    .raddr   (raddr_c),
    .rdata_c (rd_c.ch1)
  );

  pooled_frame_ram u_ram_2 (
    .clk     (clk),
    .we      (we_c),
    .waddr   (waddr_q),
    .wdata   (data_in_2),
    .raddr   (raddr_c),
    .rdata_c (rd_c.ch2)
  );

  pooled_frame_ram u_ram_3 (
    .clk     (clk),
    .we      (we_c),
    .waddr   (waddr_q),
    .wdata   (data_in_3),
    .raddr   (raddr_c),
    .rdata_c (rd_c.ch3)
  );

  // Next state, counter stepping and output staging.
  always_comb begin
    state_d      = state_q;
    waddr_d      = waddr_q;
    orow_d       = orow_q;
    ocol_d       = ocol_q;
    ky_d         = ky_q;
    kx_d         = kx_q;
    issued_d     = issued_q;
    valid_d      = valid_q;
    tap_last_d   = tap_last_q;
    frame_last_d = frame_last_q;
    data_d       = data_q;
    overflow_d   = overflow_q | (valid_in && (state_q != ST_FILL));

    case (state_q)
      ST_FILL: begin
        if (valid_in) begin
          if (waddr_q == LAST_WA) begin
            waddr_d = '0;
            state_d = ST_READ;
          end else begin
            waddr_d = waddr_q + 1'b1;
          end
        end
      end
      ST_READ: begin
        if (advance_c) begin
          data_d       = rd_c;
          valid_d      = 1'b1;
          tap_last_d   = last_tap_c;
          frame_last_d = last_tap_c && last_win_c;
          if (kx_q == K_MAX) begin
            kx_d = '0;
            if (ky_q == K_MAX) begin
              ky_d = '0;
              if (ocol_q == COL_MAX) begin
                ocol_d = '0;
                if (orow_q == ROW_MAX) begin
                  orow_d   = '0;
                  issued_d = 1'b1;
                end else begin
                  orow_d = orow_q + 1'b1;
                end
              end else begin
                ocol_d = ocol_q + 1'b1;
              end
            end else begin
              ky_d = ky_q + 1'b1;
            end
          end else begin
            kx_d = kx_q + 1'b1;
          end
        end else if (valid_q && out_ready) begin
          valid_d      = 1'b0;
          tap_last_d   = 1'b0;
          frame_last_d = 1'b0;
          if (frame_last_q) begin
            state_d  = ST_FILL;
            issued_d = 1'b0;
          end
        end
      end
      default: state_d = ST_FILL;
    endcase

    in_ready_d = (state_d == ST_FILL);
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= ST_FILL;
      waddr_q      <= '0;
      orow_q       <= '0;
      ocol_q       <= '0;
      ky_q         <= '0;
      kx_q         <= '0;
      issued_q     <= 1'b0;
      valid_q      <= 1'b0;
      tap_last_q   <= 1'b0;
      frame_last_q <= 1'b0;
      overflow_q   <= 1'b0;
      in_ready_q   <= 1'b1;
      data_q       <= '0;
    end else begin
      state_q      <= state_d;
      waddr_q      <= waddr_d;
      orow_q       <= orow_d;
      ocol_q       <= ocol_d;
      ky_q         <= ky_d;
      kx_q         <= kx_d;
      issued_q     <= issued_d;
      valid_q      <= valid_d;
      tap_last_q   <= tap_last_d;
      frame_last_q <= frame_last_d;
      overflow_q   <= overflow_d;
      in_ready_q   <= in_ready_d;
      data_q       <= data_d;
    end
  end

  assign in_ready   = in_ready_q;
  assign valid_out  = valid_q;
  assign tap_last   = tap_last_q;
  assign frame_last = frame_last_q;
  assign overflow   = overflow_q;
  assign data_out_1 = data_q.ch1;
  assign data_out_2 = data_q.ch2;
  assign data_out_3 = data_q.ch3;

endmodule

// File: tb/tb_pooled_window_reader.sv
// Randomized bench for pooled_window_reader against a frame/window reference model.
module tb_pooled_window_reader;

  localparam int W  = 12;
  localparam int H  = 12;
  localparam int K  = 5;
  localparam int FS = W * H;

  logic clk;
  logic rst_n;
  logic valid_in;
  logic signed [14:0] data_in_1, data_in_2, data_in_3;
  logic in_ready;
  logic signed [14:0] data_out_1, data_out_2, data_out_3;
  logic valid_out;
  logic out_ready;
  logic tap_last;
  logic frame_last;
  logic overflow;

  pooled_window_reader dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .valid_in   (valid_in),
    .data_in_1  (data_in_1),
    .data_in_2  (data_in_2),
    .data_in_3  (data_in_3),
    .in_ready   (in_ready),
    .data_out_1 (data_out_1),
    .data_out_2 (data_out_2),
    .data_out_3 (data_out_3),
    .valid_out  (valid_out),
    .out_ready  (out_ready),
    .tap_last   (tap_last),
    .frame_last (frame_last),
    .overflow   (overflow)
  );

  typedef struct {
    int d1;
    int d2;
    int d3;
    int tl;
    int fl;
  } tap_t;

  int vectors     = 0;
  int miscompares = 0;
  int ovf_exp     = 0;
  logic signed [14:0] m1 [FS];
  logic signed [14:0] m2 [FS];
  logic signed [14:0] m3 [FS];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input int got, input int exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Stream one frame in with random gaps; ramp or random payload.
  task automatic fill_frame(input bit ramp);
    int i;
    i = 0;
    while (i < FS) begin
      @(negedge clk);
      chk("in_ready_fill", int'(in_ready), 1);
      if ($urandom_range(3) == 0) begin
        valid_in = 1'b0;
      end else begin
        valid_in = 1'b1;
        if (ramp) begin
          data_in_1 = 15'(i);
          data_in_2 = 15'(-i);
          data_in_3 = 15'(i + 100);
        end else begin
          data_in_1 = 15'($urandom);
          data_in_2 = 15'($urandom);
          data_in_3 = 15'($urandom);
        end
        m1[i] = data_in_1;
        m2[i] = data_in_2;
        m3[i] = data_in_3;
        i++;
      end
    end
    @(negedge clk);
    valid_in = 1'b0;
    chk("in_ready_read", int'(in_ready), 0);
    chk("valid_before_first_tap", int'(valid_out), 0);
    chk("overflow_after_fill", int'(overflow), ovf_exp);
  endtask

  // Drain up to stop_after taps, with optional stall and overflow injection.
  task automatic run_frame(input int stop_after, input int stall_at, input int ovf_at,
                           input int ready_pct);
    tap_t exp_q[$];
    tap_t e;
    int taps, budget, stall_cnt, a;
    bit first, hold_prev, stall_done, ovf_done;
    int h1, h2, h3, htl, hfl;
    for (int orow = 0; orow <= H - K; orow++)
      for (int ocol = 0; ocol <= W - K; ocol++)
        for (int ky = 0; ky < K; ky++)
          for (int kx = 0; kx < K; kx++) begin
            a    = (orow + ky) * W + ocol + kx;
            e.d1 = int'(m1[a]);
            e.d2 = int'(m2[a]);
            e.d3 = int'(m3[a]);
            e.tl = (ky == K - 1 && kx == K - 1) ? 1 : 0;
            e.fl = (e.tl == 1 && orow == H - K && ocol == W - K) ? 1 : 0;
            exp_q.push_back(e);
          end
    taps = 0; budget = 0; stall_cnt = 0;
    first = 1; hold_prev = 0; stall_done = 0; ovf_done = 0;
    h1 = 0; h2 = 0; h3 = 0; htl = 0; hfl = 0;
    while (taps < stop_after && exp_q.size() > 0 && budget < 20000) begin
      @(negedge clk);
      budget++;
      valid_in = 1'b0;
      if (first) begin
        chk("first_tap_latency", int'(valid_out), 1);
        first = 0;
      end
      if (hold_prev) begin
        chk("hold_valid", int'(valid_out), 1);
        chk("hold_d1", int'(data_out_1), h1);
        chk("hold_d2", int'(data_out_2), h2);
        chk("hold_d3", int'(data_out_3), h3);
        chk("hold_tap_last", int'(tap_last), htl);
        chk("hold_frame_last", int'(frame_last), hfl);
      end
      if (valid_out && taps == stall_at && !stall_done) begin
        stall_cnt  = 4;
        stall_done = 1;
      end
      if (stall_cnt > 0) begin
        out_ready = 1'b0;
        stall_cnt--;
      end else begin
        out_ready = ($urandom_range(99) < ready_pct) ? 1'b1 : 1'b0;
      end
      if (taps == ovf_at && !ovf_done) begin
        valid_in  = 1'b1;
        data_in_1 = 15'(999);
        data_in_2 = 15'(999);
        data_in_3 = 15'(999);
        ovf_done  = 1;
        ovf_exp   = 1;
      end
      if (valid_out && out_ready) begin
        e = exp_q.pop_front();
        chk("tap_d1", int'(data_out_1), e.d1);
        chk("tap_d2", int'(data_out_2), e.d2);
        chk("tap_d3", int'(data_out_3), e.d3);
        chk("tap_last", int'(tap_last), e.tl);
        chk("frame_last", int'(frame_last), e.fl);
        taps++;
      end
      hold_prev = valid_out && !out_ready;
      h1 = int'(data_out_1); h2 = int'(data_out_2); h3 = int'(data_out_3);
      htl = int'(tap_last); hfl = int'(frame_last);
    end
    valid_in = 1'b0;
    chk("taps_issued", taps, stop_after);
    if (stop_after == (W - K + 1) * (H - K + 1) * K * K) begin
      @(negedge clk);
      chk("in_ready_after_frame", int'(in_ready), 1);
      chk("valid_after_frame", int'(valid_out), 0);
      chk("overflow_sticky", int'(overflow), ovf_exp);
    end
  endtask

  initial begin
    rst_n     = 1'b0;
    valid_in  = 1'b0;
    out_ready = 1'b0;
    data_in_1 = '0;
    data_in_2 = '0;
    data_in_3 = '0;
    repeat (3) @(negedge clk);
    chk("rst_valid_out", int'(valid_out), 0);
    chk("rst_tap_last", int'(tap_last), 0);
    chk("rst_frame_last", int'(frame_last), 0);
    chk("rst_overflow", int'(overflow), 0);
    chk("rst_d1", int'(data_out_1), 0);
    chk("rst_d2", int'(data_out_2), 0);
    chk("rst_d3", int'(data_out_3), 0);
    chk("rst_in_ready", int'(in_ready), 1);
    rst_n = 1'b1;

    // Ramp frame, full-rate drain.
    fill_frame(1'b1);
    run_frame(1600, -1, -1, 100);

    // Ramp frame with a 4-cycle stall while tap value 13 is presented.
    fill_frame(1'b1);
    run_frame(1600, 6, -1, 100);

    // Random data, random backpressure, overflow injected mid-read.
    fill_frame(1'b0);
    run_frame(1600, -1, 300, 60);

    // Following frame must be intact, overflow still set.
    fill_frame(1'b1);
    run_frame(1600, -1, -1, 80);

    // Abandon a frame with reset after 200 taps.
    fill_frame(1'b0);
    run_frame(200, -1, -1, 100);
    @(negedge clk);
    rst_n     = 1'b0;
    out_ready = 1'b0;
    @(negedge clk);
    ovf_exp = 0;
    chk("midrst_valid_out", int'(valid_out), 0);
    chk("midrst_in_ready", int'(in_ready), 1);
    chk("midrst_overflow", int'(overflow), 0);
    rst_n = 1'b1;

    fill_frame(1'b0);
    run_frame(1600, -1, -1, 70);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
